bit_grouper: RTL and testbench

Upstream stage of the sorter. Collects a serial coded-bit stream into symbol-sized groups of 2, 4, 6 or 8 bits, selected by the modulation index `M` (QPSK, 16-QAM, 64-QAM, 256-QAM). It presents each group to the sorter through a valid/ready handshake and zero-pads a trailing partial group when the frame ends. It bounds each frame with the same `start`-level framing the sorter uses and flags lost groups.

---
 rtl/bit_grouper.sv | 135 +++++++++++++
 tb/tb_bit_grouper.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_grouper.sv
// bit_grouper: packs a serial coded-bit stream into 2/4/6/8-bit symbol
// groups (selected by M at frame start), presents them through a 1-deep
// valid/ready output register, zero-pads a trailing partial group and
// flags groups dropped under backpressure.
module bit_grouper (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] M,
  input  logic       start,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       group_ready,
  output logic [7:0] group_data,
  output logic       group_valid,
  output logic       done,
  output logic       busy,
  output logic       overflow
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  m_q, m_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  data_q, data_d;
  logic        vld_q, vld_d;
  logic        ovf_q, ovf_d;

  logic [3:0]  n_bits;     // group size for the latched modulation
  logic [3:0]  cnt_inc;
  logic [3:0]  cnt_after;  // count after this cycle's bit, used for close
  logic [7:0]  sh_shift;
  logic [7:0]  padded;
  logic        grp_done;
  logic        can_load;

  assign n_bits    = {1'b0, m_q, 1'b0} + 4'd2;
  assign cnt_inc   = cnt_q + 4'd1;
  assign sh_shift  = {sh_q[6:0], bit_in};
  assign grp_done  = bit_valid && (cnt_inc == n_bits);
  assign cnt_after = !bit_valid ? cnt_q : (grp_done ? 4'd0 : cnt_inc);
  // Shift register only ever holds the current partial group, so the
  // upper bits are already zero and left-shifting pads the LSBs.
  assign padded    = sh_q << (n_bits - cnt_q);
  // Output register is free, or is being emptied on this very edge.
  assign can_load  = !vld_q || group_ready;

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= 2'd0;
      cnt_q   <= 4'd0;
      sh_q    <= 8'd0;
      data_q  <= 8'd0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: frame open/close sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_COLLECT;
      S_COLLECT: if (!start) state_d = (cnt_after != 4'd0) ? S_FLUSH : S_DONE;
      S_FLUSH:   if (can_load) state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath: bit collection, group formation and output register load.
  always_comb begin
    m_d    = m_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    data_d = data_q;
    vld_d  = vld_q;
    ovf_d  = ovf_q;
    if (vld_q && group_ready) vld_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d   = M;
          cnt_d = 4'd0;
          sh_d  = 8'd0;
          ovf_d = 1'b0;
        end
      end
      S_COLLECT: begin
        if (grp_done) begin
          cnt_d = 4'd0;
          sh_d  = 8'd0;
          if (can_load) begin
            data_d = sh_shift;
            vld_d  = 1'b1;
          end else begin
            ovf_d  = 1'b1;   // register busy: drop the new group
          end
        end else if (bit_valid) begin
          cnt_d = cnt_inc;
          sh_d  = sh_shift;
        end
      end
      S_FLUSH: begin
        if (can_load) begin
          data_d = padded;
          vld_d  = 1'b1;
          cnt_d  = 4'd0;
          sh_d   = 8'd0;
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    group_data  = data_q;
    group_valid = vld_q;
    overflow    = ovf_q;
    done        = (state_q == S_DONE);
    busy        = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_bit_grouper.sv
// Self-checking bench for bit_grouper: directed scenarios plus randomized
// frames compared cycle by cycle against a queue-based reference model.
module tb_bit_grouper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] M = 2'd0;
  logic       start = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       group_ready = 1'b0;
  logic [7:0] group_data;
  logic       group_valid;
  logic       done;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  bit_grouper dut (
    .clk(clk), .rst(rst), .M(M), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .group_ready(group_ready),
    .group_data(group_data), .group_valid(group_valid),
    .done(done), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 collecting, 2 flushing, 3 done.
  int       ph = 0;
  int       mm = 0;
  bit       bq[$];
  bit       mv = 0;
  int       md = 0;
  bit       movf = 0;

  int       obs[$];   // groups accepted by downstream
  int       ndone = 0;

  function automatic int grp_value(int n);
    int v = 0;
    foreach (bq[i]) v = v * 2 + int'(bq[i]);
    return v << (n - bq.size());
  endfunction

  task automatic mdl_reset();
    ph = 0; mm = 0; bq.delete(); mv = 0; md = 0; movf = 0;
  endtask

  task automatic mdl_next();
    int  n = 2 * (mm + 1);
    bit  can = !mv || group_ready;
    bit  nv = mv;
    int  nd = md;
    int  nph = ph;
    if (mv && group_ready) nv = 0;
    case (ph)
      0: if (start) begin mm = int'(M); bq.delete(); movf = 0; nph = 1; end
      1: begin
        if (bit_valid) begin
          bq.push_back(bit_in);
          if (bq.size() == n) begin
            if (can) begin nv = 1; nd = grp_value(n); end
            else movf = 1;
            bq.delete();
          end
        end
        if (!start) nph = (bq.size() != 0) ? 2 : 3;
      end
      2: if (can) begin nv = 1; nd = grp_value(n); bq.delete(); nph = 3; end
      default: nph = 0;
    endcase
    ph = nph; mv = nv; md = nd;
  endtask

  // One clock: note handshake before the edge, advance model, settle.
  task automatic step();
    if (group_valid && group_ready) obs.push_back(int'(group_data));
    mdl_next();
    @(posedge clk);
    #1;
    if (done) ndone++;
  endtask

  task automatic drain();
    group_ready = 1'b1; start = 1'b0; bit_valid = 1'b0;
    step(); step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (group_data !== 8'd0 || group_valid !== 1'b0 || done !== 1'b0 ||
        busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data=%h valid=%b done=%b busy=%b ovf=%b, expected all 0",
               group_data, group_valid, done, busy, overflow);
    end
    mdl_reset();
    #10 rst = 1'b0;
    step();
  endtask

  task automatic test_qpsk();
    bit b[8] = '{1,0,1,1,0,0,1,0};
    obs.delete();
    M = 2'd0; start = 1'b1; group_ready = 1'b1; step();
    foreach (b[i]) begin bit_in = b[i]; bit_valid = 1'b1; step(); end
    bit_valid = 1'b0; start = 1'b0; ndone = 0;
    step();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL qpsk_empty_close: done=%b, expected 1", done); end
    step(); step();
    checks++;
    if (obs.size() != 4 || obs[0] != 2 || obs[1] != 3 || obs[2] != 0 || obs[3] != 2) begin
      errors++; $display("FAIL qpsk_groups: got %p, expected '{2,3,0,2}", obs);
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL qpsk_done_count: got %0d, expected 1", ndone); end
  endtask

  task automatic test_qam16_flush();
    bit b[6] = '{1,1,0,1,1,0};
    obs.delete();
    M = 2'd1; start = 1'b1; group_ready = 1'b1; step();
    foreach (b[i]) begin bit_in = b[i]; bit_valid = 1'b1; step(); end
    bit_valid = 1'b0; start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL qam16_flush_state: busy=%b done=%b, expected 1 0", busy, done);
    end
    step();
    checks++;
    if (group_valid !== 1'b1 || group_data !== 8'h08 || done !== 1'b1) begin
      errors++; $display("FAIL qam16_padded: valid=%b data=%h done=%b, expected 1 08 1",
                         group_valid, group_data, done);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL qam16_idle: done=%b busy=%b, expected 0 0", done, busy);
    end
    step();
    checks++;
    if (obs.size() != 2 || obs[0] != 'h0D || obs[1] != 'h08) begin
      errors++; $display("FAIL qam16_groups: got %p, expected '{13,8}", obs);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] v = 16'hA53C;
    bit          moved = 0;
    obs.delete();
    M = 2'd3; start = 1'b1; group_ready = 1'b0; step();
    for (int i = 15; i >= 8; i--) begin bit_in = v[i]; bit_valid = 1'b1; step(); end
    checks++;
    if (group_valid !== 1'b1 || group_data !== 8'hA5 || overflow !== 1'b0) begin
      errors++; $display("FAIL bp_first: valid=%b data=%h ovf=%b, expected 1 a5 0",
                         group_valid, group_data, overflow);
    end
    for (int i = 7; i >= 0; i--) begin
      bit_in = v[i]; bit_valid = 1'b1; step();
      if (group_data !== 8'hA5 || group_valid !== 1'b1) moved = 1;
    end
    checks++;
    if (moved) begin errors++; $display("FAIL bp_stable: data=%h, expected a5 held", group_data); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: ovf=%b, expected 1", overflow); end
    bit_valid = 1'b0; start = 1'b0; step(); step();
    group_ready = 1'b1; step();
    checks++;
    if (group_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: valid=%b, expected 0", group_valid); end
    step();
    checks++;
    if (obs.size() != 1 || obs[0] != 'hA5) begin
      errors++; $display("FAIL bp_groups: got %p, expected '{165}", obs);
    end
  endtask

  task automatic test_mchange();
    bit b[12] = '{1,0,1,1,1,1,0,1,0,1,0,1};
    obs.delete();
    M = 2'd2; start = 1'b1; group_ready = 1'b1; step();
    foreach (b[i]) begin
      if (i == 2) M = 2'd0;
      bit_in = b[i]; bit_valid = 1'b1; step();
    end
    bit_valid = 1'b0; start = 1'b0; step(); step(); step();
    checks++;
    if (obs.size() != 2 || obs[0] != 'h2F || obs[1] != 'h15 || overflow !== 1'b0) begin
      errors++; $display("FAIL mchange_groups: got %p ovf=%b, expected '{47,21} 0", obs, overflow);
    end
  endtask

  task automatic test_reset_mid();
    bit b[7] = '{1,0,1,1,1,1,1};
    bit c[4] = '{0,1,1,0};
    obs.delete();
    M = 2'd1; start = 1'b1; group_ready = 1'b0; step();
    foreach (b[i]) begin bit_in = b[i]; bit_valid = 1'b1; step(); end
    checks++;
    if (group_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: valid=%b, expected 1", group_valid); end
    rst = 1'b1;
    #2;
    checks++;
    if (group_data !== 8'd0 || group_valid !== 1'b0 || done !== 1'b0 ||
        busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: data=%h valid=%b done=%b busy=%b ovf=%b, expected all 0",
               group_data, group_valid, done, busy, overflow);
    end
    mdl_reset();
    bit_valid = 1'b0; start = 1'b0;
    #1 rst = 1'b0;
    step();
    M = 2'd1; start = 1'b1; group_ready = 1'b1; step();
    foreach (c[i]) begin bit_in = c[i]; bit_valid = 1'b1; step(); end
    bit_valid = 1'b0; start = 1'b0; step(); step(); step();
    checks++;
    if (obs.size() != 1 || obs[0] != 'h06) begin
      errors++; $display("FAIL rstmid_clean: got %p, expected '{6}", obs);
    end
  endtask

  task automatic test_simul_close();
    bit b[6] = '{1,1,0,0,1,1};
    M = 2'd2; start = 1'b1; group_ready = 1'b1; step();
    foreach (b[i]) begin
      if (i == 5) start = 1'b0;
      bit_in = b[i]; bit_valid = 1'b1; step();
    end
    bit_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || group_valid !== 1'b1 || group_data !== 8'h33) begin
      errors++; $display("FAIL simul_close: done=%b valid=%b data=%h, expected 1 1 33",
                         done, group_valid, group_data);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || group_valid !== 1'b0) begin
      errors++; $display("FAIL simul_after: done=%b busy=%b valid=%b, expected 0 0 0",
                         done, busy, group_valid);
    end
  endtask

  task automatic compare_model(string tag);
    int n_bad;
    checks++;
    n_bad = 0;
    if (group_valid !== mv || group_data !== md[7:0] || done !== (ph == 3) ||
        busy !== (ph != 0) || overflow !== movf) n_bad = 1;
    if (n_bad != 0) begin
      errors++;
      $display("FAIL %s: valid=%b data=%h done=%b busy=%b ovf=%b, expected %b %h %b %b %b",
               tag, group_valid, group_data, done, busy, overflow,
               mv, md[7:0], ph == 3, ph != 0, movf);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(0, 30);
      bit bp = $urandom_range(0, 1) == 1;
      M = 2'($urandom); start = 1'b1; bit_valid = 1'($urandom);
      step(); compare_model("rand_open");
      for (int c = 0; c < len; c++) begin
        M = 2'($urandom);
        bit_in = 1'($urandom);
        bit_valid = ($urandom_range(0, 3) != 0);
        group_ready = bp ? ($urandom_range(0, 3) == 0) : 1'b1;
        step(); compare_model("rand_collect");
      end
      start = 1'b0;
      for (int c = 0; c < 20 && busy; c++) begin
        bit_in = 1'($urandom); bit_valid = 1'($urandom);
        group_ready = 1'($urandom);
        step(); compare_model("rand_close");
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rand_timeout: busy=%b, expected 0", busy); end
      step(); compare_model("rand_idle");
    end
  endtask

  initial begin
    test_reset();
    test_qpsk();
    drain();
    test_qam16_flush();
    drain();
    test_backpressure();
    drain();
    test_mchange();
    drain();
    test_reset_mid();
    drain();
    test_simul_close();
    drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
